// File: rtl/muldiv_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_issue_ctrl_pkg
// Shared definitions for the execute-stage multiply/divide front end and the
// fixed-latency MulDivUnit behind it.
//   MulDivCode      : 3-bit operation code (RISC-V M-extension funct3 order)
//   MulDivState     : issue controller FSM states
//   MUL_DIV_LATENCY : launch-to-result latency of MulDivUnit, in cycles
// ---------------------------------------------------------------------------
package muldiv_issue_ctrl_pkg;

    localparam int MUL_DIV_LATENCY = 8;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } MulDivCode;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } MulDivState;

endpackage

// File: rtl/muldiv_special_case.sv
// ---------------------------------------------------------------------------
// muldiv_special_case
// Combinational detector for the divide cases whose RISC-V result is fixed
// by definition, so they can complete without launching MulDivUnit.
//   code        in  3           MulDivCode of the instruction
//   op1, op2    in  DATA_WIDTH  dividend / divisor
//   is_fast     out 1           op is divide-by-zero or signed overflow
//   fast_result out DATA_WIDTH  architecturally defined result for that case
// ---------------------------------------------------------------------------
module muldiv_special_case
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            code,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  is_fast,
    output logic [DATA_WIDTH-1:0] fast_result
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEGATIVE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    MulDivCode w_code;
    logic      w_isDiv;
    logic      w_isRem;
    logic      w_isSigned;
    logic      w_divByZero;
    logic      w_overflow;

    assign w_code      = MulDivCode'(code);
    assign w_isDiv     = (w_code == DIV) || (w_code == DIVU) || (w_code == REM) || (w_code == REMU);
    assign w_isRem     = (w_code == REM) || (w_code == REMU);
    assign w_isSigned  = (w_code == DIV) || (w_code == REM);
    assign w_divByZero = w_isDiv && (op2 == '0);
    // Only the signed ops can overflow: most-negative / -1.
    assign w_overflow  = w_isSigned && (op1 == MOST_NEGATIVE) && (op2 == '1);

    // Divide-by-zero takes priority; the two cases cannot overlap anyway
    // because overflow requires a divisor of all ones.
    always_comb begin
        is_fast     = w_divByZero || w_overflow;
        fast_result = '0;
        if (w_divByZero) begin
            fast_result = w_isRem ? op1 : '1;
        end else if (w_overflow) begin
            fast_result = w_isRem ? '0 : MOST_NEGATIVE;
        end
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_issue_ctrl
// Execute-stage front end for the multi-cycle MulDivUnit. Launches a MulDiv
// op, stalls the pipeline until the unit's result is due, short-circuits the
// fixed-result divide cases, and hands a tagged result to EX/MEM.
//   clk, rst                    clock / synchronous active-low reset
//   flush                       branch-mispredict flush (drops in-flight op)
//   in_valid, in_is_muldiv      ID/EX slot qualifiers
//   in_code, in_op1, in_op2     operation and operands
//   in_rd, in_wr_en             destination tag and write enable
//   unit_code, unit_op1/op2     registered launch values to MulDivUnit
//   unit_result                 MulDivUnit output, due LATENCY cycles later
//   stall                       hold IF/ID/EX while an op is outstanding
//   out_valid                   one-cycle completion pulse
//   out_result, out_rd          held until the next completion
//   out_wr_en                   write enable, never set for rd = 0
// ---------------------------------------------------------------------------
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int LATENCY        = MUL_DIV_LATENCY,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic                      in_is_muldiv,
    input  logic [2:0]                in_code,
    input  logic [DATA_WIDTH-1:0]     in_op1,
    input  logic [DATA_WIDTH-1:0]     in_op2,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_wr_en,
    output logic [2:0]                unit_code,
    output logic [DATA_WIDTH-1:0]     unit_op1,
    output logic [DATA_WIDTH-1:0]     unit_op2,
    input  logic [DATA_WIDTH-1:0]     unit_result,
    output logic                      stall,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_wr_en
);

    localparam int CNT_W = $clog2(LATENCY);

    MulDivState                r_state;
    MulDivState                w_nextState;
    logic [CNT_W-1:0]          r_count;
    logic [2:0]                r_unitCode;
    logic [DATA_WIDTH-1:0]     r_unitOp1;
    logic [DATA_WIDTH-1:0]     r_unitOp2;
    logic [REG_ADDR_WIDTH-1:0] r_tagRd;
    logic                      r_tagWrEn;
    logic [DATA_WIDTH-1:0]     r_outResult;
    logic [REG_ADDR_WIDTH-1:0] r_outRd;
    logic                      r_outWrEn;

    logic                      w_accept;
    logic                      w_isFast;
    logic [DATA_WIDTH-1:0]     w_fastResult;

    // Accept is only possible from IDLE; DONE ignores the still-present
    // instruction that just completed.
    assign w_accept = rst && (r_state == IDLE) && in_valid && in_is_muldiv && !flush;

    muldiv_special_case #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_specialCase (
        .code        (in_code),
        .op1         (in_op1),
        .op2         (in_op2),
        .is_fast     (w_isFast),
        .fast_result (w_fastResult)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state. Flush wins over every transition, so an op in BUSY is
    // abandoned and the unit's eventual result is never latched.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_nextState = w_isFast ? DONE : BUSY;
            BUSY:    if (r_count == '0) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (flush) begin
            w_nextState = IDLE;
        end
    end

    // Counter, launch registers and result registers. Output result/tag are
    // only written at a completion, so a flush leaves the last delivered
    // value visible but revokes its write enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= '0;
            r_unitCode  <= '0;
            r_unitOp1   <= '0;
            r_unitOp2   <= '0;
            r_tagRd     <= '0;
            r_tagWrEn   <= 1'b0;
            r_outResult <= '0;
            r_outRd     <= '0;
            r_outWrEn   <= 1'b0;
        end else if (flush) begin
            r_count   <= '0;
            r_outWrEn <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_isFast) begin
                            r_outResult <= w_fastResult;
                            r_outRd     <= in_rd;
                            r_outWrEn   <= in_wr_en && (in_rd != '0);
                        end else begin
                            r_unitCode <= in_code;
                            r_unitOp1  <= in_op1;
                            r_unitOp2  <= in_op2;
                            r_tagRd    <= in_rd;
                            r_tagWrEn  <= in_wr_en;
                            r_count    <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (r_count == '0) begin
                        r_outResult <= unit_result;
                        r_outRd     <= r_tagRd;
                        r_outWrEn   <= r_tagWrEn && (r_tagRd != '0);
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall      = w_accept || (r_state == BUSY);
    assign out_valid  = (r_state == DONE);
    assign out_result = r_outResult;
    assign out_rd     = r_outRd;
    assign out_wr_en  = r_outWrEn;
    assign unit_code  = r_unitCode;
    assign unit_op1   = r_unitOp1;
    assign unit_op2   = r_unitOp2;

endmodule
